// File: rtl/ras_checkpointed.sv
// ras_checkpointed -- return-address stack with a single rollback checkpoint.
//
// Calls push a return address and returns pop it. The top entry is presented
// as the predicted return target. One snapshot slot captures the whole stack
// so that speculative calls and returns can be undone after a mispredict.
//
// Ports:
//   clk_i        core clock, rising edge
//   rst_i        asynchronous active-high reset
//   flush_bp_i   invalidate all entries and the snapshot
//   push_i       push data_i
//   pop_i        pop the top entry
//   data_i       return address to push
//   checkpoint_i snapshot the current (pre-update) stack and count
//   restore_i    reload stack and count from the snapshot
//   top_valid_o  top entry valid
//   top_ra_o     top entry address
//   count_o      number of valid entries, 0..DEPTH
//   ckpt_valid_o snapshot slot holds a valid snapshot
//   overflow_o   one-cycle pulse: a push discarded the bottom entry
//
// Priority per cycle: rst_i > flush_bp_i > restore_i > {push_i, pop_i}.
// All outputs come straight from registers.
module ras_checkpointed #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned VLEN  = 32
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        flush_bp_i,
  input  logic                        push_i,
  input  logic                        pop_i,
  input  logic [VLEN-1:0]             data_i,
  input  logic                        checkpoint_i,
  input  logic                        restore_i,
  output logic                        top_valid_o,
  output logic [VLEN-1:0]             top_ra_o,
  output logic [$clog2(DEPTH+1)-1:0]  count_o,
  output logic                        ckpt_valid_o,
  output logic                        overflow_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  // Entry 0 is the top of the stack; valid bit i belongs to entry i.
  logic [DEPTH-1:0] stack_valid_q, stack_valid_d;
  logic [VLEN-1:0]  stack_ra_q [DEPTH];
  logic [VLEN-1:0]  stack_ra_d [DEPTH];
  logic [CNT_W-1:0] count_q, count_d;

  logic [DEPTH-1:0] ckpt_valid_bits_q, ckpt_valid_bits_d;
  logic [VLEN-1:0]  ckpt_ra_q [DEPTH];
  logic [VLEN-1:0]  ckpt_ra_d [DEPTH];
  logic [CNT_W-1:0] ckpt_count_q, ckpt_count_d;
  logic             ckpt_valid_q, ckpt_valid_d;

  logic             overflow_q, overflow_d;

  always_comb begin
    stack_valid_d     = stack_valid_q;
    stack_ra_d        = stack_ra_q;
    count_d           = count_q;
    ckpt_valid_bits_d = ckpt_valid_bits_q;
    ckpt_ra_d         = ckpt_ra_q;
    ckpt_count_d      = ckpt_count_q;
    ckpt_valid_d      = ckpt_valid_q;
    overflow_d        = 1'b0;

    if (flush_bp_i) begin
      stack_valid_d = '0;
      count_d       = '0;
      ckpt_valid_d  = 1'b0;
    end else begin
      if (restore_i) begin
        if (ckpt_valid_q) begin
          stack_valid_d = ckpt_valid_bits_q;
          stack_ra_d    = ckpt_ra_q;
          count_d       = ckpt_count_q;
        end
      end else if (push_i && pop_i) begin
        // Return immediately followed by a call: only the top is replaced.
        stack_valid_d[0] = 1'b1;
        stack_ra_d[0]    = data_i;
        if (count_q == '0) count_d = CNT_W'(1);
      end else if (push_i) begin
        stack_valid_d    = stack_valid_q << 1;
        stack_valid_d[0] = 1'b1;
        for (int unsigned i = 1; i < DEPTH; i++) stack_ra_d[i] = stack_ra_q[i-1];
        stack_ra_d[0] = data_i;
        if (count_q == FULL) overflow_d = 1'b1;
        else                 count_d    = count_q + CNT_W'(1);
      end else if (pop_i) begin
        // Popping an empty stack leaves everything untouched.
        if (count_q != '0) begin
          stack_valid_d = stack_valid_q >> 1;
          for (int unsigned i = 0; i + 1 < DEPTH; i++) stack_ra_d[i] = stack_ra_q[i+1];
          count_d = count_q - CNT_W'(1);
        end
      end

      // Snapshot takes the register values, i.e. the state before this
      // cycle's push/pop/restore; a same-cycle restore still used the old one.
      if (checkpoint_i) begin
        ckpt_valid_bits_d = stack_valid_q;
        ckpt_ra_d         = stack_ra_q;
        ckpt_count_d      = count_q;
        ckpt_valid_d      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stack_valid_q     <= '0;
      count_q           <= '0;
      ckpt_valid_bits_q <= '0;
      ckpt_count_q      <= '0;
      ckpt_valid_q      <= 1'b0;
      overflow_q        <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stack_ra_q[i] <= '0;
        ckpt_ra_q[i]  <= '0;
      end
    end else begin
      stack_valid_q     <= stack_valid_d;
      stack_ra_q        <= stack_ra_d;
      count_q           <= count_d;
      ckpt_valid_bits_q <= ckpt_valid_bits_d;
      ckpt_ra_q         <= ckpt_ra_d;
      ckpt_count_q      <= ckpt_count_d;
      ckpt_valid_q      <= ckpt_valid_d;
      overflow_q        <= overflow_d;
    end
  end

  assign top_valid_o  = stack_valid_q[0];
  assign top_ra_o     = stack_ra_q[0];
  assign count_o      = count_q;
  assign ckpt_valid_o = ckpt_valid_q;
  assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_ras_checkpointed.sv
// Testbench for ras_checkpointed (DEPTH=2, VLEN=32): directed vectors with
// hand-computed expected outputs pushed into a scoreboard queue; a monitor
// compares the DUT outputs after each clock edge.
module tb_ras_checkpointed;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        flush_bp_i, push_i, pop_i, checkpoint_i, restore_i;
  logic [31:0] data_i;
  logic        top_valid_o;
  logic [31:0] top_ra_o;
  logic [1:0]  count_o;
  logic        ckpt_valid_o;
  logic        overflow_o;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    string       name;
    logic        tv;
    logic [31:0] ra;
    logic        chk_ra;
    logic [1:0]  cnt;
    logic        cv;
    logic        ov;
  } exp_t;

  exp_t sb[$];

  ras_checkpointed #(.DEPTH(2), .VLEN(32)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_bp_i  (flush_bp_i),
    .push_i      (push_i),
    .pop_i       (pop_i),
    .data_i      (data_i),
    .checkpoint_i(checkpoint_i),
    .restore_i   (restore_i),
    .top_valid_o (top_valid_o),
    .top_ra_o    (top_ra_o),
    .count_o     (count_o),
    .ckpt_valid_o(ckpt_valid_o),
    .overflow_o  (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic compare(input exp_t e);
    bit bad;
    n_vec++;
    bad = (top_valid_o !== e.tv) || (count_o !== e.cnt) ||
          (ckpt_valid_o !== e.cv) || (overflow_o !== e.ov) ||
          (e.chk_ra && (top_ra_o !== e.ra));
    if (bad) begin
      n_err++;
      $display("FAIL %s: got tv=%b ra=%h cnt=%0d cv=%b ov=%b, want tv=%b ra=%h(chk=%b) cnt=%0d cv=%b ov=%b",
               e.name, top_valid_o, top_ra_o, count_o, ckpt_valid_o, overflow_o,
               e.tv, e.ra, e.chk_ra, e.cnt, e.cv, e.ov);
    end
  endtask

  // Monitor: one expectation per clock edge that had stimulus applied.
  always @(posedge clk_i) begin
    #1;
    if (sb.size() > 0) compare(sb.pop_front());
  end

  // Drive one cycle of inputs (at negedge) and queue the outputs expected
  // after the following rising edge. tv=0 entries have a don't-care address.
  task automatic step(input string name, input bit fl, input bit rs, input bit ck,
                      input bit pu, input bit po, input logic [31:0] d,
                      input logic tv, input logic [31:0] ra, input logic [1:0] cnt,
                      input logic cv, input logic ov);
    exp_t e;
    @(negedge clk_i);
    flush_bp_i = fl; restore_i = rs; checkpoint_i = ck;
    push_i = pu; pop_i = po; data_i = d;
    e.name = name; e.tv = tv; e.ra = ra; e.chk_ra = tv; e.cnt = cnt; e.cv = cv; e.ov = ov;
    sb.push_back(e);
  endtask

  task automatic direct(input string name, input logic tv, input logic [1:0] cnt,
                        input logic cv, input logic ov);
    exp_t e;
    e.name = name; e.tv = tv; e.ra = '0; e.chk_ra = 1'b1; e.cnt = cnt; e.cv = cv; e.ov = ov;
    compare(e);
  endtask

  initial begin
    int t;
    rst_i = 1'b1;
    flush_bp_i = 0; restore_i = 0; checkpoint_i = 0; push_i = 0; pop_i = 0; data_i = '0;
    #23;
    direct("in_reset", 0, 0, 0, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    //   name            fl rs ck pu po data      tv ra        cnt cv ov
    step("reset_idle",    0, 0, 0, 0, 0, 32'h0,    0, 32'h0,    0, 0, 0);
    step("push_100",      0, 0, 0, 1, 0, 32'h100,  1, 32'h100,  1, 0, 0);
    step("push_200",      0, 0, 0, 1, 0, 32'h200,  1, 32'h200,  2, 0, 0);
    step("pop_to_100",    0, 0, 0, 0, 1, 32'h0,    1, 32'h100,  1, 0, 0);
    step("pop_empty",     0, 0, 0, 0, 1, 32'h0,    0, 32'h0,    0, 0, 0);
    step("pop_on_empty",  0, 0, 0, 0, 1, 32'h0,    0, 32'h0,    0, 0, 0);
    step("ovf_push_a",    0, 0, 0, 1, 0, 32'hA,    1, 32'hA,    1, 0, 0);
    step("ovf_push_b",    0, 0, 0, 1, 0, 32'hB,    1, 32'hB,    2, 0, 0);
    step("ovf_push_c",    0, 0, 0, 1, 0, 32'hC,    1, 32'hC,    2, 0, 1);
    step("ovf_pulse_end", 0, 0, 0, 0, 0, 32'h0,    1, 32'hC,    2, 0, 0);
    step("ovf_pop_b",     0, 0, 0, 0, 1, 32'h0,    1, 32'hB,    1, 0, 0);
    step("ovf_pop_empty", 0, 0, 0, 0, 1, 32'h0,    0, 32'h0,    0, 0, 0);
    step("pp_push_20",    0, 0, 0, 1, 0, 32'h20,   1, 32'h20,   1, 0, 0);
    step("pp_push_10",    0, 0, 0, 1, 0, 32'h10,   1, 32'h10,   2, 0, 0);
    step("pushpop_30",    0, 0, 0, 1, 1, 32'h30,   1, 32'h30,   2, 0, 0);
    step("pp_next_20",    0, 0, 0, 0, 1, 32'h0,    1, 32'h20,   1, 0, 0);
    step("pp_pop_empty",  0, 0, 0, 0, 1, 32'h0,    0, 32'h0,    0, 0, 0);
    step("restore_noval", 0, 1, 0, 0, 0, 32'h0,    0, 32'h0,    0, 0, 0);
    step("ck_push_40",    0, 0, 0, 1, 0, 32'h40,   1, 32'h40,   1, 0, 0);
    step("ck_and_push50", 0, 0, 1, 1, 0, 32'h50,   1, 32'h50,   2, 1, 0);
    step("ck_pop_1",      0, 0, 0, 0, 1, 32'h0,    1, 32'h40,   1, 1, 0);
    step("ck_pop_2",      0, 0, 0, 0, 1, 32'h0,    0, 32'h0,    0, 1, 0);
    step("restore_40",    0, 1, 0, 0, 0, 32'h0,    1, 32'h40,   1, 1, 0);
    step("push_60",       0, 0, 0, 1, 0, 32'h60,   1, 32'h60,   2, 1, 0);
    step("restore_push",  0, 1, 0, 1, 0, 32'h70,   1, 32'h40,   1, 1, 0);
    step("restore_exact", 0, 0, 0, 0, 1, 32'h0,    0, 32'h0,    0, 1, 0);
    step("push_80",       0, 0, 0, 1, 0, 32'h80,   1, 32'h80,   1, 1, 0);
    step("ck_restore",    0, 1, 1, 0, 0, 32'h0,    1, 32'h40,   1, 1, 0);
    step("restore_new",   0, 1, 0, 0, 0, 32'h0,    1, 32'h80,   1, 1, 0);
    step("flush_all",     1, 1, 1, 1, 0, 32'h90,   0, 32'h0,    0, 0, 0);
    step("restore_aft_fl",0, 1, 0, 0, 0, 32'h0,    0, 32'h0,    0, 0, 0);
    step("rst_push_1",    0, 0, 0, 1, 0, 32'h1,    1, 32'h1,    1, 0, 0);
    step("rst_push_2",    0, 0, 0, 1, 0, 32'h2,    1, 32'h2,    2, 0, 0);
    step("rst_push_3",    0, 0, 0, 1, 0, 32'h3,    1, 32'h3,    2, 0, 1);
    @(negedge clk_i);
    push_i = 0;
    // Drain the scoreboard with a bounded wait.
    t = 0;
    while (sb.size() > 0 && t < 20) begin
      @(posedge clk_i); #2; t++;
    end
    if (sb.size() > 0) begin
      n_vec++; n_err++;
      $display("FAIL drain_timeout: got %0d pending, want 0", sb.size());
    end
    // Mid-cycle async reset while the overflow pulse of the last push would
    // still be on the outputs if the edge had just happened.
    @(posedge clk_i); #3;
    rst_i = 1'b1;
    #1;
    direct("async_reset", 0, 0, 0, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    step("post_reset",    0, 0, 0, 0, 0, 32'h0,    0, 32'h0,    0, 0, 0);
    @(posedge clk_i); #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ras_checkpointed.md
Name: ras_checkpointed

Overview:
- Return-address stack for the CVA6 frontend branch predictor.
- Sized by the core configuration's RASDepth, which is 2 for the 32-bit IMAC/Sv32 build.
- Frontend pushes on call and pops on return. It consumes the top entry as the predicted return target.
- A single checkpoint slot allows the stack to be rolled back when a speculative call/return is squashed by a mispredict.

Parameters:
- DEPTH, 2, number of stack entries (≥1; from cva6_cfg.RASDepth).
- VLEN, 32, return-address width in bits (from cva6_cfg XLEN).
- CNT_W, $clog2(DEPTH+1), occupancy counter width (derived, not overridable).

Ports:
- clk_i  in  1  core clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- flush_bp_i  in  1  invalidate all entries and the checkpoint.
- push_i  in  1  push data_i (call predicted/decoded).
- pop_i  in  1  pop top entry (return predicted).
- data_i  in  VLEN  return address to push.
- checkpoint_i  in  1  snapshot current stack state.
- restore_i  in  1  reload stack from snapshot.
- top_valid_o  out  1  top entry valid.
- top_ra_o  out  VLEN  top entry address.
- count_o  out  CNT_W  valid entries, 0..DEPTH.
- ckpt_valid_o  out  1  snapshot slot holds a valid snapshot.
- overflow_o  out  1  one-cycle pulse: a push discarded the bottom entry.

Behaviour:
- State:
  - stack[0..DEPTH-1], each entry {valid, ra}; entry 0 is the top.
  - count register.
  - Checkpoint copy of stack+count plus ckpt_valid.
  - overflow register.
- Outputs: top_valid_o/top_ra_o = stack[0] and count_o = count. All are driven from registers, with no combinational path from inputs. overflow_o is registered.
- Reset (async, rst_i=1):
  - All valid bits = 0; all ra = 0; count = 0.
  - ckpt_valid = 0; overflow_o = 0.
  - Outputs therefore read 0 during reset and the first cycle after.
- Per-cycle priority: rst_i > flush_bp_i > restore_i > {push_i, pop_i}. Lower-priority requests in the same cycle are ignored entirely.
- Flush:
  - Clear every entry valid bit, count=0, ckpt_valid=0.
  - ra contents are don't-care.
- Restore:
  - If ckpt_valid=1: stack and count are loaded from the snapshot next cycle. ckpt_valid stays 1, so the snapshot can be reused.
  - If ckpt_valid=0: no state change.
- Push only:
  - Shift entries down by one; entry 0 = {1, data_i}; entry DEPTH-1 is discarded.
  - count = min(count+1, DEPTH).
  - If count==DEPTH before the push, overflow_o=1 in the next cycle.
- Pop only:
  - Shift entries up by one; entry DEPTH-1 valid=0.
  - count = count-1, saturating at 0.
  - Pop on empty: state is unchanged except entry valid bits remain 0; no error.
- Push and pop together:
  - Replace the top: entry 0 = {1, data_i}; other entries unchanged.
  - count = max(count,1). No overflow.
- Checkpoint:
  - Captures the stack+count as they were before any same-cycle push/pop (the current register values). Sets ckpt_valid=1.
  - Checkpoint with restore in the same cycle: restore uses the old snapshot, then the snapshot is overwritten with the pre-restore state.
  - Checkpoint with flush in the same cycle: flush wins and ckpt_valid=0.
- Latency: every update becomes visible on the outputs one cycle after the request.
- Reset asserted mid-operation clears everything asynchronously, including a pending overflow pulse.

Test Plan:
- Reset then idle:
  - Apply reset, then release.
  - Expect top_valid_o=0, count_o=0, ckpt_valid_o=0, overflow_o=0.
- Push/pop sequence:
  - Push 0x100, then push 0x200. Expect top=0x200, count=2.
  - Pop. Expect top=0x100, count=1.
  - Pop. Expect top_valid_o=0, count=0.
  - Pop again. Expect no change and no X.
- Overflow (DEPTH=2):
  - Push 0xA, 0xB, 0xC. On the third push, overflow_o pulses for exactly one cycle.
  - Expect top=0xC, count=2.
  - Two pops yield 0xC then 0xB, then the stack is empty.
- Simultaneous push+pop:
  - With the stack holding 0x10 over 0x20, assert push+pop with 0x30.
  - Expect top=0x30, next entry 0x20, count=2, no overflow.
- Checkpoint/restore:
  - Push 0x40, then checkpoint+push(0x50) in the same cycle.
  - Pop twice. Expect count=0.
  - Restore. Expect top=0x40, count=1, ckpt_valid_o=1.
  - A restore issued with ckpt_valid=0 leaves the state unchanged.
- Priority:
  - Flush+restore+push in the same cycle: expect count=0 and ckpt_valid_o=0.
  - Restore+push in the same cycle: the restored state is exact and the push is ignored.
  - Assert rst_i asynchronously mid-cycle: outputs clear immediately.
